ahb_decoder_mux: RTL and testbench

- Slave-side stage directly downstream of the AHB arbiter.
- Takes the granted master's address-phase signals and decodes HADDR against the shared slave address map into a one-hot HSEL.
- Registers the selected slave index into the data phase, then multiplexes that slave's HRDATA/HREADYOUT/HRESP back toward the masters.
- Contains a built-in default slave that returns the two-cycle AHB ERROR response for unmapped active transfers.

---
 rtl/integration_pkg.sv | 32 +++
 rtl/ahb_default_slave.sv | 55 +++++
 rtl/ahb_decoder_mux.sv | 92 +++++++++
 tb/tb_ahb_decoder_mux.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/integration_pkg.sv
// Shared AHB integration definitions: slave address map, bus enums and
// the default-slave state type used by the decoder/mux.
package integration_pkg;

  localparam int slave_number = 4;

  localparam logic [31:0] slave_low_address  [slave_number] = '{32'd0,  32'd32, 32'd64, 32'd96};
  localparam logic [31:0] slave_high_address [slave_number] = '{32'd31, 32'd63, 32'd95, 32'd126};

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } transfer_t;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } resp_t;

  localparam int DEFAULT_SLAVE = slave_number;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers unmapped active transfers with the
// two-cycle AHB ERROR response, and a zero-wait OKAY otherwise.
module ahb_default_slave
  import integration_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  unmapped,
  input  logic  trans_active,
  input  logic  hready,
  output logic  ready,
  output resp_t resp
);

  ds_state_t state;
  logic      err_start;

  assign err_start = hready && unmapped && trans_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DS_IDLE;
      ready <= 1'b1;
      resp  <= OKAY;
    end else begin
      case (state)
        DS_IDLE: begin
          if (err_start) begin
            state <= DS_ERR1;
            ready <= 1'b0;
            resp  <= ERROR;
          end
        end
        DS_ERR1: begin
          state <= DS_ERR2;
          ready <= 1'b1;
          resp  <= ERROR;
        end
        default: begin
          // ERR2 completes the error; a new unmapped access restarts it directly.
          if (err_start) begin
            state <= DS_ERR1;
            ready <= 1'b0;
            resp  <= ERROR;
          end else begin
            state <= DS_IDLE;
            ready <= 1'b1;
            resp  <= OKAY;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB slave-side decoder and response multiplexer: decodes HADDR to a
// one-hot HSEL, tracks the data-phase slave and muxes its response back.
module ahb_decoder_mux
  import integration_pkg::*;
#(
  parameter int SLAVE_NUMBER = slave_number,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [ADDR_W-1:0]            haddr_i,
  input  logic [1:0]                   htrans_i,
  output logic [SLAVE_NUMBER-1:0]      hsel_o,
  input  logic [SLAVE_NUMBER-1:0]      hreadyout_s_i,
  input  logic [2*SLAVE_NUMBER-1:0]    hresp_s_i,
  input  logic [DATA_W*SLAVE_NUMBER-1:0] hrdata_s_i,
  output logic                         hready_o,
  output logic [1:0]                   hresp_o,
  output logic [DATA_W-1:0]            hrdata_o
);

  localparam int                SEL_W        = $clog2(SLAVE_NUMBER + 1);
  localparam logic [SEL_W-1:0]  DSEL_DEFAULT = SEL_W'(SLAVE_NUMBER);

  logic [SEL_W-1:0] dec_idx;
  logic [SEL_W-1:0] dsel;
  logic             dactive;
  logic             unmapped;
  logic             ds_ready;
  resp_t            ds_resp;
  logic [ADDR_W:0]  lo_diff;
  logic [ADDR_W:0]  hi_diff;

  // Address phase: range match via borrow bits; descending scan lets the lowest index win.
  always_comb begin
    hsel_o  = '0;
    dec_idx = DSEL_DEFAULT;
    lo_diff = '0;
    hi_diff = '0;
    for (int i = SLAVE_NUMBER - 1; i >= 0; i--) begin
      lo_diff = {1'b0, haddr_i} - {1'b0, ADDR_W'(slave_low_address[i])};
      hi_diff = {1'b0, ADDR_W'(slave_high_address[i])} - {1'b0, haddr_i};
      if (!lo_diff[ADDR_W] && !hi_diff[ADDR_W]) begin
        hsel_o    = '0;
        hsel_o[i] = 1'b1;
        dec_idx   = SEL_W'(i);
      end
    end
  end

  assign unmapped = (dec_idx == DSEL_DEFAULT);

  // Data phase: selection advances only when the bus accepts the address phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel    <= DSEL_DEFAULT;
      dactive <= 1'b0;
    end else if (hready_o) begin
      dsel    <= dec_idx;
      dactive <= htrans_i[1];
    end
  end

  ahb_default_slave u_ds (
    .clk          (HCLK),
    .rst          (HRESET),
    .unmapped     (unmapped),
    .trans_active (htrans_i[1]),
    .hready       (hready_o),
    .ready        (ds_ready),
    .resp         (ds_resp)
  );

  always_comb begin
    hready_o = ds_ready;
    hresp_o  = ds_resp;
    hrdata_o = '0;
    for (int i = 0; i < SLAVE_NUMBER; i++) begin
      if (dsel == SEL_W'(i)) begin
        hready_o = hreadyout_s_i[i];
        hresp_o  = hresp_s_i[2*i +: 2];
        hrdata_o = hrdata_s_i[DATA_W*i +: DATA_W];
      end
    end
  end

  // dactive is kept for data-phase observers; the mux itself does not need it.
  logic unused_ok;
  assign unused_ok = ^{dactive, htrans_i[0]};

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Bench for ahb_decoder_mux: directed scenarios plus randomized traffic
// checked against a transfer-level reference model.
module tb_ahb_decoder_mux;
  import integration_pkg::*;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [31:0]  haddr_i;
  logic [1:0]   htrans_i;
  logic [3:0]   hsel_o;
  logic [3:0]   hreadyout_s_i;
  logic [7:0]   hresp_s_i;
  logic [127:0] hrdata_s_i;
  logic         hready_o;
  logic [1:0]   hresp_o;
  logic [31:0]  hrdata_o;

  int checks = 0;
  int errors = 0;

  // Reference model: slave owning the current data phase (4 = default),
  // and which cycle of an error response is in progress (0 none, 1 first, 2 second).
  int m_sel;
  int m_err;

  logic [3:0]  obs_hsel;
  logic        obs_ready;
  logic [1:0]  obs_resp;
  logic [31:0] obs_rdata;

  localparam logic [127:0] DEF_RD = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

  ahb_decoder_mux dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .haddr_i       (haddr_i),
    .htrans_i      (htrans_i),
    .hsel_o        (hsel_o),
    .hreadyout_s_i (hreadyout_s_i),
    .hresp_s_i     (hresp_s_i),
    .hrdata_s_i    (hrdata_s_i),
    .hready_o      (hready_o),
    .hresp_o       (hresp_o),
    .hrdata_o      (hrdata_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_dec(input logic [31:0] a);
    if (a < 32)  return 0;
    if (a < 64)  return 1;
    if (a < 96)  return 2;
    if (a < 127) return 3;
    return 4;
  endfunction

  // One bus cycle: drive at posedge+1, check before the next edge, advance the model.
  task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [3:0] rdy,
                      input logic [7:0] rsp, input logic [127:0] rd);
    int          d;
    logic [3:0]  e_hsel;
    logic        e_ready;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    haddr_i       = a;
    htrans_i      = t;
    hreadyout_s_i = rdy;
    hresp_s_i     = rsp;
    hrdata_s_i    = rd;
    #3;
    d      = ref_dec(a);
    e_hsel = (d == 4) ? 4'b0000 : (4'b0001 << d);
    if (m_sel == 4) begin
      e_ready = (m_err != 1);
      e_resp  = (m_err != 0) ? 2'b01 : 2'b00;
      e_rdata = '0;
    end else begin
      e_ready = rdy[m_sel];
      e_resp  = rsp[2*m_sel +: 2];
      e_rdata = rd[32*m_sel +: 32];
    end
    obs_hsel  = hsel_o;
    obs_ready = hready_o;
    obs_resp  = hresp_o;
    obs_rdata = hrdata_o;
    chk("hsel",   obs_hsel,  e_hsel);
    chk("hready", obs_ready, e_ready);
    chk("hresp",  obs_resp,  e_resp);
    chk("hrdata", obs_rdata, e_rdata);
    @(posedge HCLK);
    #1;
    if (e_ready) begin
      m_sel = d;
      m_err = (d == 4 && t[1]) ? 1 : 0;
    end else if (m_err == 1) begin
      m_err = 2;
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [3:0]  rr;
    HRESET        = 1'b1;
    haddr_i       = 32'd0;
    htrans_i      = IDLE;
    hreadyout_s_i = 4'hF;
    hresp_s_i     = 8'h00;
    hrdata_s_i    = DEF_RD;
    m_sel         = 4;
    m_err         = 0;
    #1;
    chk("rst_ready", hready_o, 1'b1);
    chk("rst_resp",  hresp_o,  2'b00);
    chk("rst_rdata", hrdata_o, 32'h0);
    chk("rst_dsel",  dut.dsel, 3'd4);
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Mapped read at 40
    step(32'd40, NONSEQ, 4'hF, 8'h00, DEF_RD);
    chk("map_hsel40", obs_hsel, 4'b0010);
    step(32'd0, IDLE, 4'hF, 8'h00, DEF_RD);
    chk("map_rdata", obs_rdata, 32'hA5A5_0001);
    chk("map_ready", obs_ready, 1'b1);

    // Asynchronous reset mid-cycle while slave 1 owns a stalled data phase
    step(32'd40, NONSEQ, 4'hF, 8'h00, DEF_RD);
    hreadyout_s_i = 4'b1101;
    hrdata_s_i    = {32'h3, 32'h2, 32'hDEAD_BEEF, 32'h0};
    hresp_s_i     = 8'b00_00_01_00;
    #2;
    chk("pre_rst_ready", hready_o, 1'b0);
    chk("pre_rst_rdata", hrdata_o, 32'hDEAD_BEEF);
    HRESET = 1'b1;
    #1;
    chk("mid_rst_ready", hready_o, 1'b1);
    chk("mid_rst_resp",  hresp_o,  2'b00);
    chk("mid_rst_rdata", hrdata_o, 32'h0);
    chk("mid_rst_dsel",  dut.dsel, 3'd4);
    chk("mid_rst_hsel",  hsel_o,   4'b0010);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    m_sel  = 4;
    m_err  = 0;

    // Wait states from slave 2, next address held
    step(32'd70, NONSEQ, 4'hF, 8'h00, DEF_RD);
    for (int k = 0; k < 3; k++) begin
      step(32'd0, NONSEQ, 4'b1011, 8'h00, DEF_RD);
      chk("ws_ready_low", obs_ready, 1'b0);
      chk("ws_dsel_hold", dut.dsel, 3'd2);
    end
    step(32'd0, NONSEQ, 4'hF, 8'h00, DEF_RD);
    chk("ws_ready_high", obs_ready, 1'b1);
    chk("ws_dsel_next",  dut.dsel, 3'd0);

    // Unmapped at 127
    step(32'd127, NONSEQ, 4'hF, 8'h00, DEF_RD);
    chk("unm_hsel", obs_hsel, 4'b0000);
    step(32'd0, IDLE, 4'hF, 8'h00, DEF_RD);
    chk("unm_err1_ready", obs_ready, 1'b0);
    chk("unm_err1_resp",  obs_resp,  2'b01);
    step(32'd0, IDLE, 4'hF, 8'h00, DEF_RD);
    chk("unm_err2_ready", obs_ready, 1'b1);
    chk("unm_err2_resp",  obs_resp,  2'b01);
    step(32'd0, IDLE, 4'hF, 8'h00, DEF_RD);
    chk("unm_after_resp", obs_resp, 2'b00);

    // Back-to-back: error followed by slave 3 accepted during ERR2
    step(32'd500, NONSEQ, 4'hF, 8'h00, DEF_RD);
    step(32'd500, IDLE, 4'hF, 8'h00, DEF_RD);
    chk("b2b_err1_ready", obs_ready, 1'b0);
    step(32'd96, NONSEQ, 4'hF, 8'h00, DEF_RD);
    chk("b2b_err2_ready", obs_ready, 1'b1);
    chk("b2b_err2_resp",  obs_resp,  2'b01);
    chk("b2b_dsel",       dut.dsel,  3'd3);
    chk("b2b_fsm_idle",   dut.u_ds.state, DS_IDLE);
    step(32'd0, IDLE, 4'hF, 8'h00, DEF_RD);
    chk("b2b_s3_rdata", obs_rdata, 32'hA5A5_0003);
    chk("b2b_s3_resp",  obs_resp,  2'b00);

    // IDLE to an unmapped address
    step(32'd500, IDLE, 4'hF, 8'h00, DEF_RD);
    chk("idle_unm_fsm", dut.u_ds.state, DS_IDLE);
    step(32'd0, IDLE, 4'hF, 8'h00, DEF_RD);
    chk("idle_unm_ready", obs_ready, 1'b1);
    chk("idle_unm_resp",  obs_resp,  2'b00);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom_range(0, 130);
        1:       ra = 32'd127;
        2:       ra = $urandom;
        default: ra = $urandom_range(0, 600);
      endcase
      for (int b = 0; b < 4; b++) rr[b] = ($urandom_range(0, 3) != 0);
      step(ra, 2'($urandom), rr, 8'($urandom), {$urandom, $urandom, $urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
